// File: rtl/acc_uart_tx.sv
// Serial transmitter for a 16-bit accumulator word: two 8N1 bytes, low byte first.
// Define ACC_TX_PARITY_EN to add an even-parity bit per byte (8E1).
module acc_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic [15:0] acc_in_i,
  input  logic        wr_out_i,
  output logic        tx_o,
  output logic        ready_o,
  output logic        overrun_o
);

  // state    | meaning
  // S_IDLE   | line high, waiting for wr_out_i
  // S_START  | start bit (low)
  // S_DATA   | 8 data bits, LSB first
  // S_PARITY | even parity over the byte (ACC_TX_PARITY_EN builds only)
  // S_STOP   | stop bit (high), then next byte or idle
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef ACC_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        byte_idx_q, byte_idx_d;
  logic [15:0] hold_q, hold_d;
  logic        tx_q, tx_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  cur_byte;

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 1'b0;
      hold_q     <= 16'h0000;
      tx_q       <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    hold_d     = hold_q;
    overrun_d  = overrun_q | (wr_out_i && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (wr_out_i) begin
          hold_d     = acc_in_i;
          byte_idx_d = 1'b0;
          bit_idx_d  = 3'd0;
          timer_d    = BIT_RELOAD;
          state_d    = S_START;
        end
      end
      default: begin
        if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          timer_d = BIT_RELOAD;
          case (state_q)
            S_START: begin
              bit_idx_d = 3'd0;
              state_d   = S_DATA;
            end
            S_DATA: begin
              if (bit_idx_q == 3'd7) begin
                bit_idx_d = 3'd0;
`ifdef ACC_TX_PARITY_EN
                state_d   = S_PARITY;
`else
                state_d   = S_STOP;
`endif
              end else begin
                bit_idx_d = bit_idx_q + 3'd1;
              end
            end
`ifdef ACC_TX_PARITY_EN
            S_PARITY: state_d = S_STOP;
`endif
            S_STOP: begin
              if (!byte_idx_q) begin
                byte_idx_d = 1'b1;
                state_d    = S_START;
              end else begin
                state_d    = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Tx is computed from the next-state values so the flop lines up with state_q.
  assign cur_byte = byte_idx_d ? hold_d[15:8] : hold_d[7:0];

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte[bit_idx_d];
`ifdef ACC_TX_PARITY_EN
      S_PARITY: tx_d = ^cur_byte;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_o      = tx_q;
  assign ready_o   = (state_q == S_IDLE);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_acc_uart_tx.sv
// Directed self-checking bench for acc_uart_tx at CLKS_PER_BIT=4.
module tb_acc_uart_tx;

  localparam int CPB = 4;
`ifdef ACC_TX_PARITY_EN
  localparam int BL = 11;
`else
  localparam int BL = 10;
`endif
  localparam int FRAME_CYC = 2 * BL * CPB;

  logic        clk;
  logic        rst_n;
  logic [15:0] acc;
  logic        wr;
  logic        tx, ready, overrun;
  int          n_checks = 0;
  int          n_fail = 0;

  acc_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .acc_in_i (acc),
    .wr_out_i (wr),
    .tx_o     (tx),
    .ready_o  (ready),
    .overrun_o(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit k of a word frame (start, 8 data LSB first, [parity], stop).
  function automatic logic exp_bit(input logic [15:0] w, input int k);
    int         byte_no;
    int         pos;
    logic [7:0] d;
    byte_no = k / BL;
    pos     = k % BL;
    d       = (byte_no == 0) ? w[7:0] : w[15:8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if (BL == 11 && pos == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic start_word(input logic [15:0] w);
    wr  = 1'b1;
    acc = w;
    @(negedge clk);
  endtask

  // Entered at the negedge of the first START cycle; returns at the negedge of the first idle cycle.
  task automatic check_frame(input string tag, input logic [15:0] w, input int poke,
                             input bit hold, input logic [15:0] next_acc);
    for (int i = 0; i < FRAME_CYC; i++) begin
      chk($sformatf("%s tx c%0d", tag, i), {31'd0, tx}, {31'd0, exp_bit(w, i / CPB)});
      chk($sformatf("%s busy c%0d", tag, i), {31'd0, ready}, 32'd0);
      if (hold) begin
        if (i == 0) chk($sformatf("%s ovr_clear", tag), {31'd0, overrun}, 32'd0);
        if (i == 1) chk($sformatf("%s ovr_set", tag), {31'd0, overrun}, 32'd1);
        wr  = 1'b1;
        acc = next_acc;
      end else begin
        wr  = (i == poke);
        acc = (i == poke) ? 16'h1234 : ~w;
      end
      @(negedge clk);
    end
    chk($sformatf("%s ready_end", tag), {31'd0, ready}, 32'd1);
    chk($sformatf("%s tx_idle", tag), {31'd0, tx}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    acc   = 16'h0000;
    repeat (2) @(negedge clk);
    wr = 1'b1;
    acc = 16'hFFFF;
    @(negedge clk);
    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("rst tx", {31'd0, tx}, 32'd1);
    chk("rst overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    wr    = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle ready", {31'd0, ready}, 32'd1);

    start_word(16'hA53C);
    check_frame("a53c", 16'hA53C, -1, 1'b0, 16'h0);
    chk("a53c ovr", {31'd0, overrun}, 32'd0);

    start_word(16'h00FF);
    check_frame("00ff", 16'h00FF, -1, 1'b0, 16'h0);
    start_word(16'h0107);
    check_frame("0107", 16'h0107, -1, 1'b0, 16'h0);

    start_word(16'hBEEF);
    check_frame("beef", 16'hBEEF, 10, 1'b0, 16'h0);
    chk("beef ovr", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("no2nd tx %0d", i), {31'd0, tx}, 32'd1);
      chk($sformatf("no2nd ready %0d", i), {31'd0, ready}, 32'd1);
      @(negedge clk);
    end
    chk("ovr sticky", {31'd0, overrun}, 32'd1);

    start_word(16'h5A5A);
    wr = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort tx", {31'd0, tx}, 32'd1);
    chk("abort ready", {31'd0, ready}, 32'd1);
    chk("abort ovr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("abort idle %0d", i), {31'd0, tx}, 32'd1);
      @(negedge clk);
    end
    start_word(16'h0001);
    check_frame("0001", 16'h0001, -1, 1'b0, 16'h0);

    start_word(16'h0001);
    check_frame("b2b1", 16'h0001, -1, 1'b1, 16'h0002);
    @(negedge clk);
    check_frame("b2b2", 16'h0002, -1, 1'b0, 16'h0);
    chk("b2b ovr", {31'd0, overrun}, 32'd1);
    repeat (5) @(negedge clk);
    chk("b2b no3rd", {31'd0, ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
